// File: rtl/rate_divider_pkg.sv
// Rate-select encodings and reload-value helper for rate_divider; pure constants, no state.
// Latency: n/a. Backpressure: n/a.
package rate_div_pkg;

   typedef enum logic [1:0] {
      RATE_FULL = 2'd0,
      RATE_1HZ  = 2'd1,
      RATE_HALF = 2'd2,
      RATE_QTR  = 2'd3
   } rate_sel_e;

   // Result is 64 bits wide; callers cast it down to their counter width.
   function automatic logic [63:0] rate_reload(input logic [1:0] sel, input int clk_hz);
      logic [63:0] hz;
      hz = 64'(clk_hz);
      case (sel)
         RATE_FULL: rate_reload = 64'd0;
         RATE_1HZ:  rate_reload = hz - 64'd1;
         RATE_HALF: rate_reload = (hz << 1) - 64'd1;
         default:   rate_reload = (hz << 2) - 64'd1;
      endcase
   endfunction

endpackage

// File: rtl/rate_divider_if.sv
// Control/status bundle between the rate divider and its user; master drives en/sel.
// Latency: n/a. Backpressure: none, tick is a fire-and-forget pulse.
interface rate_divider_if #(
   parameter int CNT_W = 28
);
   logic             en;
   logic [1:0]       sel;
   logic             tick;
   logic [CNT_W-1:0] cnt_q;

   modport master (output en, sel, input tick, cnt_q);
   modport slave  (input en, sel, output tick, cnt_q);
endinterface

// File: rtl/rate_divider_sync2.sv
// Generic W-bit two-flop synchronizer with synchronous active-high reset to zero.
// Latency: 2 cycles. Backpressure: none.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/rate_divider.sv
// Divides clk into a one-cycle tick every R(sel)+1 cycles; tick is registered (1 cycle after cnt hits 0).
// No backpressure. RATE_DIVIDER_SYNC_EN adds 2-flop synchronizers on en/sel (2 extra cycles of latency).
module rate_divider
   import rate_div_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int CNT_W  = 28
) (
   input  logic          clk,
   input  logic          rset,
   rate_divider_if.slave bus
);
   localparam logic [63:0] MAX_RELOAD = rate_reload(RATE_QTR, CLK_HZ);

   generate
      if ((MAX_RELOAD >> CNT_W) != 64'd0) begin : g_bad_width
         $error("rate_divider: CNT_W too narrow for 4*CLK_HZ-1");
      end
   endgenerate

   logic             w_en;
   logic [1:0]       w_sel;
   logic [1:0]       w_rst_sel;
   logic [CNT_W-1:0] w_reload;
   logic [CNT_W-1:0] w_rst_reload;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sel_q;
   logic             r_tick;

`ifdef RATE_DIVIDER_SYNC_EN
   logic [2:0] w_sync;

   sync2 #(.W(3)) u_sync (
      .clk  (clk),
      .rset (rset),
      .i_d  ({bus.en, bus.sel}),
      .o_q  (w_sync)
   );

   assign w_en      = w_sync[2];
   assign w_sel     = w_sync[1:0];
   // The synchronizer is cleared by the same reset, so the post-reset rate is always RATE_FULL.
   assign w_rst_sel = RATE_FULL;
`else
   assign w_en      = bus.en;
   assign w_sel     = bus.sel;
   assign w_rst_sel = bus.sel;
`endif

   assign w_reload     = CNT_W'(rate_reload(w_sel, CLK_HZ));
   assign w_rst_reload = CNT_W'(rate_reload(w_rst_sel, CLK_HZ));

   always_ff @(posedge clk) begin
      if (rset) begin
         r_cnt   <= w_rst_reload;
         r_sel_q <= w_rst_sel;
         r_tick  <= 1'b0;
      end else if (w_sel != r_sel_q) begin
         // A rate change restarts the period and suppresses any tick due this cycle.
         r_cnt   <= w_reload;
         r_sel_q <= w_sel;
         r_tick  <= 1'b0;
      end else if (!w_en) begin
         r_tick <= 1'b0;
      end else if (r_cnt == '0) begin
         r_cnt  <= w_reload;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt - 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign bus.tick  = r_tick;
   assign bus.cnt_q = r_cnt;
endmodule

// File: tb/tb_rate_divider.sv
// Randomized + directed bench for rate_divider with a queue scoreboard fed by a behavioural model.
module tb_rate_divider;
   localparam int CLK_HZ = 4;
   localparam int CNT_W  = 6;

   logic clk;
   logic rset;

   rate_divider_if #(.CNT_W(CNT_W)) bus ();

   rate_divider #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rset (rset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int tick;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk;
   int   n_pass;

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
   endtask

   // Behavioural model: period length derived from the rate, state advanced per the rule priorities.
   int m_cnt, m_sel_q, m_tick;
   int s_en[2];
   int s_sel[2];

   function automatic int rld(input int s);
      return (s == 0) ? 0 : (CLK_HZ * (1 << (s - 1))) - 1;
   endfunction

   task automatic model(input int rst, input int en, input int sel);
      int ue, us;
`ifdef RATE_DIVIDER_SYNC_EN
      ue = s_en[1];
      us = s_sel[1];
`else
      ue = en;
      us = sel;
`endif
      if (rst != 0) begin
`ifdef RATE_DIVIDER_SYNC_EN
         m_cnt   = rld(0);
         m_sel_q = 0;
`else
         m_cnt   = rld(sel);
         m_sel_q = sel;
`endif
         m_tick = 0;
      end else if (us != m_sel_q) begin
         m_cnt   = rld(us);
         m_sel_q = us;
         m_tick  = 0;
      end else if (ue == 0) begin
         m_tick = 0;
      end else if (m_cnt == 0) begin
         m_tick = 1;
         m_cnt  = rld(us);
      end else begin
         m_cnt  = m_cnt - 1;
         m_tick = 0;
      end
      if (rst != 0) begin
         s_en  = '{0, 0};
         s_sel = '{0, 0};
      end else begin
         s_en[1]  = s_en[0];
         s_en[0]  = en;
         s_sel[1] = s_sel[0];
         s_sel[0] = sel;
      end
   endtask

   task automatic step(input int rst, input int en, input int sel);
      exp_t e;
      rset    = (rst != 0);
      bus.en  = (en != 0);
      bus.sel = 2'(sel);
      model(rst, en, sel);
      e.tick = m_tick;
      e.cnt  = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expected entry per driven edge, compared 1 time unit after that edge.
   always @(posedge clk) begin
      exp_t got;
      #1;
      if (exp_q.size() > 0) begin
         got = exp_q.pop_front();
         check("tick", int'(bus.tick), got.tick);
         check("cnt_q", int'(bus.cnt_q), got.cnt);
      end
   end

   initial begin
      int ticks, n, hit, cur_sel, r_rst, r_en;
      n_chk   = 0;
      n_pass  = 0;
      rset    = 1'b0;
      bus.en  = 1'b0;
      bus.sel = 2'd1;
      s_en    = '{0, 0};
      s_sel   = '{0, 0};

      // Reset at 1 Hz rate, then free-run for 12 cycles.
      step(1, 0, 1);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 1);
         ticks += int'(bus.tick);
      end
`ifndef RATE_DIVIDER_SYNC_EN
      check("ticks_in_12_at_sel1", ticks, 3);
`endif

      // Full rate.
      for (int i = 0; i < 6; i++) step(0, 1, 0);

      // Quarter rate, pause mid-count, resume.
      step(0, 0, 3);
      for (int i = 0; i < 5; i++) step(0, 1, 3);
      for (int i = 0; i < 10; i++) step(0, 0, 3);
`ifndef RATE_DIVIDER_SYNC_EN
      check("held_cnt", int'(bus.cnt_q), 10);
`endif
      n = 0;
      hit = 0;
      for (int i = 0; i < 40 && hit == 0; i++) begin
         step(0, 1, 3);
         n++;
         hit = int'(bus.tick);
      end
      check("resume_tick_seen", hit, 1);
`ifndef RATE_DIVIDER_SYNC_EN
      check("resume_latency", n, 11);
`endif

      // Rate change on the edge where a tick would have fired.
      hit = 0;
      for (int i = 0; i < 40 && hit == 0; i++) begin
         step(0, 1, 2);
         hit = (bus.cnt_q == '0) ? 1 : 0;
      end
      check("wait_cnt0", hit, 1);
      step(0, 1, 1);
`ifndef RATE_DIVIDER_SYNC_EN
      check("selchg_tick", int'(bus.tick), 0);
      check("selchg_cnt", int'(bus.cnt_q), 3);
      n = 0;
      hit = 0;
      for (int i = 0; i < 20 && hit == 0; i++) begin
         step(0, 1, 1);
         n++;
         hit = int'(bus.tick);
      end
      check("selchg_next_tick", n, 4);
`endif

      // Reset mid-count at half rate.
      hit = 0;
      for (int i = 0; i < 40 && hit == 0; i++) begin
         step(0, 1, 2);
         hit = (bus.cnt_q == 6'd5) ? 1 : 0;
      end
      check("wait_cnt5", hit, 1);
      step(1, 1, 2);
`ifndef RATE_DIVIDER_SYNC_EN
      check("rst_mid_cnt", int'(bus.cnt_q), 7);
      check("rst_mid_tick", int'(bus.tick), 0);
`endif

      // Random traffic.
      cur_sel = 2;
      for (int i = 0; i < 400; i++) begin
         r_rst = ($urandom_range(0, 39) == 0) ? 1 : 0;
         r_en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         if ($urandom_range(0, 9) == 0) cur_sel = int'($urandom_range(0, 3));
         step(r_rst, r_en, cur_sel);
      end

      @(posedge clk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rate_divider.md
Name: rate_divider

Overview:
- Upstream enable generator for the 8-bit T-flip-flop counter/hex display stage.
- Divides the board clock (CLOCK_50) into a one-cycle `tick` pulse at a selectable rate.
- `tick` drives the counter's enable input, so the count advances at a human-visible rate.
- Replaces the manual KEY[0]/SW[1] stepping with a clocked, rate-controlled enable.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; base period of the 1 Hz rate.
- CNT_W, 28, down-counter width; must satisfy 2^CNT_W > 4*CLK_HZ-1 (elaboration-time check required).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rset  in  1  reset; one clock; reset is synchronous and active-high.
- en  in  1  run enable; low freezes the divider.
- sel  in  2  rate select: 0 = every cycle, 1 = 1 Hz, 2 = 0.5 Hz, 3 = 0.25 Hz.
- tick  out  1  registered one-cycle enable pulse to the downstream counter.
- cnt_q  out  CNT_W  current down-counter value (debug/verification visibility).

Behaviour:
- Reload value R(sel), computed at CNT_W bits:
  - R(0) = 0
  - R(1) = CLK_HZ-1
  - R(2) = 2*CLK_HZ-1
  - R(3) = 4*CLK_HZ-1
- Registers:
  - cnt (CNT_W bits)
  - sel_q (2 bits, the previous sel)
  - tick (1 bit)
- Reset (rset=1 at posedge; overrides everything):
  - cnt <= R(sel), sel_q <= sel, tick <= 0.
- Priority per posedge, after reset (highest first):
  1. Sel change (sel != sel_q): cnt <= R(sel), tick <= 0, sel_q <= sel. This applies regardless of en, and no tick is produced even if cnt==0 that cycle.
  2. en=0: cnt holds, tick <= 0.
  3. en=1 and cnt==0: tick <= 1, cnt <= R(sel).
  4. en=1 and cnt!=0: cnt <= cnt-1, tick <= 0.
- Period and latency:
  - With en held high and sel stable, tick is high for exactly 1 cycle every R(sel)+1 cycles.
  - sel=0 gives tick high on every cycle after the first.
- en behaviour:
  - First tick after reload arrives R(sel)+1 cycles after en rises.
  - en dropping mid-count preserves the partial count; resuming continues from the held value.
- Wrap-around: cnt never underflows; it only decrements from nonzero values.
- tick is never high for two consecutive cycles unless sel=0.
- Reset mid-count discards the partial count; no tick is emitted in the cycle following reset.

Optional Feature:
- Macro: RATE_DIVIDER_SYNC_EN
- Defined:
  - en and sel each pass through a 2-flop synchronizer clocked by clk before use.
  - Synchronizer flops reset to 0 on rset.
  - All en/sel effects in Behaviour are delayed by 2 cycles.
  - Sel-change detection compares the synchronized sel against sel_q.
  - On reset, cnt loads R(0), since the synchronized sel is 0.
- Not defined:
  - en and sel are used directly.
  - Inputs are assumed synchronous to clk.

Decomposition:
- Package rate_div_pkg holds:
  - Sel encodings RATE_FULL=2'd0, RATE_1HZ=2'd1, RATE_HALF=2'd2, RATE_QTR=2'd3.
  - A reload function R(sel, CLK_HZ), returning CNT_W bits.
- One sub-module, sync2: a generic 2-flop synchronizer with synchronous active-high reset.
  - Instantiated only under RATE_DIVIDER_SYNC_EN; one instance per bit, or width-parameterized.
- The down-counter and control logic stay in rate_divider.

Test Plan (CLK_HZ=4, CNT_W=6, macro undefined unless stated):
- Reset with sel=1: rset high 1 cycle -> cnt_q=3, tick=0. Then en=1 for 12 cycles -> tick high on cycles 4, 8, 12 only; cnt_q sequence is 3,2,1,0,3,...
- sel=0, en=1 -> tick=1 every cycle from the 1st posedge after en; cnt_q stays 0.
- sel=3, en=1 for 5 cycles, then en=0 for 10 cycles -> cnt_q held at 10, tick=0 throughout. Then en=1 -> first tick 11 cycles later.
- sel=2 with cnt_q=0, change sel to 1 on that edge -> no tick, cnt_q=3. The next tick comes 4 cycles later.
- rset asserted while cnt_q=5 (sel=2) -> next cycle cnt_q=7, tick=0, even with en=1.
- RATE_DIVIDER_SYNC_EN defined, sel=1, en raised at cycle 0 -> cnt_q starts decrementing at cycle 2. First tick arrives 2 cycles later than in the unsynchronized run.
